vdp_cpu_fifo: RTL
=================

Name: vdp_cpu_fifo

Overview:
CPU-side write buffer that sits directly upstream of the VDP's mode/read/write/data_in/rdy port. It accepts single-cycle CPU write strobes into a small FIFO and replays each entry as a correctly shaped VDP write: data and mode are held while write is high, and mode is still held when write falls. It also honours VDP rdy back-pressure and spaces VRAM data writes so the CPU rarely has to stall.

Parameters:
DEPTH, 8, FIFO entries (power of 2, minimum 2).
HOLD_CYCLES, 2, minimum clk cycles vdp_write stays high.
GAP_CYCLES, 8, idle clk cycles after a mode-2 (VRAM data) write, covering the VDP's 4-dot memory slot.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpu_wr  input  1  one-cycle write strobe
cpu_rd  input  1  one-cycle read strobe
cpu_addr  input  2  0..2 = VDP mode 0..2; 3 = bridge status/control
cpu_data_in  input  8  write data
cpu_data_out  output  8  registered read data
cpu_rdy  output  1  CPU may issue a write
vdp_mode  output  2  to VDP mode
vdp_write  output  1  to VDP write
vdp_read  output  1  to VDP read; tied 0 in this revision
vdp_data  output  8  to VDP data_in
vdp_rdy  input  1  from VDP rdy

Behaviour:
- Reset (async, active-high), effective immediately:
  - vdp_write=0, vdp_read=0, vdp_mode=0, vdp_data=0.
  - cpu_data_out=0, cpu_rdy=1.
  - FIFO empty, overflow=0, FSM=IDLE.
- Reset mid-transaction drops vdp_write at once; no partial entry is replayed.
- Enqueue: cpu_wr with cpu_addr!=3 pushes {addr[1:0], data[7:0]} (10 bits).
- Control write: cpu_wr with cpu_addr==3 and data bit0=1 flushes the FIFO (read pointer := write pointer). It is not enqueued.
- Status read: cpu_rd with cpu_addr==3 registers the following onto cpu_data_out on the next clk edge, then clears overflow on that same edge:
  - bit7 = full
  - bit6 = empty
  - bit5 = overflow
  - bits4:0 = level (0..DEPTH)
- Other reads: cpu_rd with cpu_addr!=3 returns 0.
- Level width: clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Push when full (feature off): data dropped, overflow set (sticky).
- Flush in the same cycle as a push: flush wins and the push is discarded.
- Drain FSM:
  - IDLE: if FIFO non-empty, pop the head and load vdp_mode/vdp_data -> PRESENT. vdp_write rises on the 2nd clk edge after the edge that sampled cpu_wr into an empty FIFO.
  - PRESENT: vdp_write=1, mode/data held; counter counts up. Exit when counter >= HOLD_CYCLES-1 and vdp_rdy==1 -> RELEASE. While vdp_rdy is low, stay in PRESENT indefinitely.
  - RELEASE: vdp_write=0 for exactly 1 cycle, mode/data still held. Next state is GAP if the entry's mode==2, else IDLE.
  - GAP: vdp_write=0 for GAP_CYCLES cycles -> IDLE.
- Minimum spacing between vdp_write rising edges:
  - modes 0/1: HOLD_CYCLES+2
  - mode 2: HOLD_CYCLES+2+GAP_CYCLES
- Flush during PRESENT/RELEASE/GAP: the in-flight entry completes normally; the remaining entries are discarded.
- mode 3 entries cannot exist (address 3 is never enqueued).
- cpu_rdy:
  - feature off: constant 1.
  - feature on: ~full, registered; see below.

Optional Feature:
Macro VDP_CPU_FIFO_STALL_EN.
- Defined:
  - cpu_rdy = ~full, updated every cycle.
  - A push while full is still dropped and still sets overflow. CPU-side logic is expected to wait on cpu_rdy.
  - Status bit5 still reports overflow.
- Undefined: cpu_rdy tied to 1; overflow is the only indication of loss.

Test Plan:
- Reset, then write addr0=0x05, addr1=0x12 -> vdp_mode=0, data=0x05 with write high 2 cycles, then mode=1, data=0x12. Mode and data stable across each vdp_write falling edge. Edge spacing 4 cycles.
- Write addr2 with 0xAA, 0xBB, 0xCC back-to-back -> three vdp_write pulses; rising edges 12 cycles apart; FIFO level peaks at 2.
- Hold vdp_rdy=0 for 20 cycles during a mode-2 PRESENT -> vdp_write stays high for those 20 cycles; falls exactly 1 cycle after vdp_rdy returns to 1 (earliest HOLD_CYCLES met).
- With vdp_rdy=0, push 10 entries (DEPTH=8) -> status read = 0xA8 (full, overflow, level 8). Second status read: bit5 clear. With VDP_CPU_FIFO_STALL_EN, cpu_rdy=0 while full.
- Queue 5 entries, write addr3=0x01 during the first PRESENT -> the first entry completes; no further vdp_write; status = 0x40.
- Assert reset while vdp_write=1 -> vdp_write=0 in the same cycle (async); status after release = 0x40.

Source files
------------

// File: rtl/vdp_cpu_fifo.sv
// CPU-side write buffer replaying CPU strobes as shaped VDP writes.
// Define VDP_CPU_FIFO_STALL_EN to drive cpu_rdy from the FIFO full flag.
module vdp_cpu_fifo #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_data_in,
    output logic [7:0] cpu_data_out,
    output logic       cpu_rdy,
    output logic [1:0] vdp_mode,
    output logic       vdp_write,
    output logic       vdp_read,
    output logic [7:0] vdp_data,
    input  logic       vdp_rdy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [LW-1:0]   level_nxt;
    logic            overflow;
    logic            avail_q;

    logic            full;
    logic            empty;
    logic            is_ctl;
    logic            push_req;
    logic            flush;
    logic            push;
    logic            drop;
    logic            pop;
    logic            stat_rd;
    logic [9:0]      head;
    logic [4:0]      level5;
    logic [7:0]      status;

    assign full     = (level == LVL_FULL);
    assign empty    = (level == '0);
    assign is_ctl   = (cpu_addr == 2'd3);
    assign push_req = cpu_wr & ~is_ctl;
    assign flush    = cpu_wr & is_ctl & cpu_data_in[0];
    assign push     = push_req & ~full;
    assign drop     = push_req & full;
    assign stat_rd  = cpu_rd & is_ctl;
    assign head     = mem[rd_ptr];
    assign level5   = 5'(level);
    assign status   = {full, empty, overflow, level5};
    assign vdp_read = 1'b0;

    // A freshly written entry settles for one cycle before the drain sees it
    assign pop = (state == S_IDLE) & avail_q & ~empty;

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cpu_addr, cpu_data_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            avail_q  <= 1'b0;
        end else begin
            level    <= level_nxt;
            avail_q  <= ~empty;
            overflow <= (overflow & ~stat_rd) | drop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_data_out <= '0;
        end else if (stat_rd) begin
            cpu_data_out <= status;
        end else if (cpu_rd) begin
            cpu_data_out <= '0;
        end
    end

`ifdef VDP_CPU_FIFO_STALL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdy <= 1'b1;
        end else begin
            cpu_rdy <= (level_nxt != LVL_FULL);
        end
    end
`else
    assign cpu_rdy = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (pop) begin
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (cnt >= HOLD_LAST && vdp_rdy) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt < HOLD_LAST) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                cnt_nxt   = '0;
                state_nxt = (vdp_mode == 2'd2) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered off the next state so they switch with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            vdp_write <= 1'b0;
            vdp_mode  <= '0;
            vdp_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vdp_write <= (state_nxt == S_PRESENT);
            if (pop) begin
                vdp_mode <= head[9:8];
                vdp_data <= head[7:0];
            end
        end
    end

endmodule
